// File: rtl/key_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : key_pkg
//  Description : Shared types and default constants for the key conditioning
//                path (debounce FSM state encoding, 50 MHz cycle defaults).
//  Revision    : 1.0 - initial release
// ============================================================================
package key_pkg;

   // Debounce FSM state encoding
   typedef enum logic [1:0] {
      ST_IDLE       = 2'd0,
      ST_PRESS_DB   = 2'd1,
      ST_HELD       = 2'd2,
      ST_RELEASE_DB = 2'd3
   } key_state_t;

   // 20 ms debounce window at 50 MHz
   localparam int unsigned c_DEF_DEBOUNCE_CYCLES = 1_000_000;
   // 1 s long-press threshold at 50 MHz
   localparam int unsigned c_DEF_LONG_CYCLES     = 50_000_000;

endpackage : key_pkg
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
//  Module      : sync_2ff
//  Description : Generic two-flop synchroniser for asynchronous inputs, with
//                a configurable reset value so an idle pin level can be
//                presented from reset without a false edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff #(
   parameter int unsigned        WIDTH       = 1,
   parameter logic [WIDTH-1:0]   RESET_VALUE = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] i_async,
   output logic [WIDTH-1:0] o_sync
);

   logic [WIDTH-1:0] r_meta;
   logic [WIDTH-1:0] r_sync;

   // Two-stage capture: first stage may go metastable, second stage resolves it
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_meta <= RESET_VALUE;
         r_sync <= RESET_VALUE;
      end else begin
         r_meta <= i_async;
         r_sync <= r_meta;
      end
   end

   assign o_sync = r_sync;

endmodule : sync_2ff
`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : key_debounce
//  Description : Synchronises a raw key pin, rejects bounces shorter than a
//                programmable window and produces a debounced level plus
//                single-cycle press / release / long-press pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module key_debounce
   import key_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = c_DEF_DEBOUNCE_CYCLES,
   parameter int unsigned LONG_CYCLES     = c_DEF_LONG_CYCLES,
   parameter logic        ACTIVE_LEVEL    = 1'b1
) (
   input  logic sys_clk,
   input  logic sys_rst,
   input  logic key_in,
   output logic key_level,
   output logic key_press,
   output logic key_release,
   output logic key_long
);

   localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int unsigned HOLD_W = $clog2(LONG_CYCLES + 1);

   localparam logic [DB_W-1:0]   c_DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [DB_W-1:0]   c_DB_ONE    = DB_W'(1);
   localparam logic [HOLD_W-1:0] c_HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
   localparam logic [HOLD_W-1:0] c_HOLD_ONE  = HOLD_W'(1);

   // Synchronised pin and its "pressed" interpretation
   logic w_key_sync;
   logic w_key_act;

   // Registered state
   key_state_t        r_state;
   logic [DB_W-1:0]   r_db_cnt;
   logic [HOLD_W-1:0] r_hold_cnt;
   logic              r_long_done;
   logic              r_level;
   logic              r_press;
   logic              r_release;
   logic              r_long;

   // Next-state values
   key_state_t        w_state_nxt;
   logic [DB_W-1:0]   w_db_cnt_nxt;
   logic [HOLD_W-1:0] w_hold_cnt_nxt;
   logic              w_long_done_nxt;
   logic              w_level_nxt;
   logic              w_press_nxt;
   logic              w_release_nxt;
   logic              w_long_nxt;

   // The pin idles at the inactive level, so the synchroniser resets there
   sync_2ff #(
      .WIDTH       (1),
      .RESET_VALUE (~ACTIVE_LEVEL)
   ) u_key_sync (
      .clk     (sys_clk),
      .rst     (sys_rst),
      .i_async (key_in),
      .o_sync  (w_key_sync)
   );

   assign w_key_act = (w_key_sync == ACTIVE_LEVEL);

   // State, counters and all outputs are registered together
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         r_state     <= ST_IDLE;
         r_db_cnt    <= '0;
         r_hold_cnt  <= '0;
         r_long_done <= 1'b0;
         r_level     <= 1'b0;
         r_press     <= 1'b0;
         r_release   <= 1'b0;
         r_long      <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_db_cnt    <= w_db_cnt_nxt;
         r_hold_cnt  <= w_hold_cnt_nxt;
         r_long_done <= w_long_done_nxt;
         r_level     <= w_level_nxt;
         r_press     <= w_press_nxt;
         r_release   <= w_release_nxt;
         r_long      <= w_long_nxt;
      end
   end

   // Next-state, counter and pulse decode; pulses default low so each lasts one cycle
   always_comb begin
      w_state_nxt     = r_state;
      w_db_cnt_nxt    = r_db_cnt;
      w_hold_cnt_nxt  = r_hold_cnt;
      w_long_done_nxt = r_long_done;
      w_level_nxt     = r_level;
      w_press_nxt     = 1'b0;
      w_release_nxt   = 1'b0;
      w_long_nxt      = 1'b0;

      unique case (r_state)
         ST_IDLE: begin
            w_level_nxt = 1'b0;
            if (w_key_act) begin
               w_state_nxt  = ST_PRESS_DB;
               w_db_cnt_nxt = '0;
            end
         end

         ST_PRESS_DB: begin
            if (!w_key_act) begin
               // Too short to be a press: drop back silently
               w_state_nxt = ST_IDLE;
            end else if (r_db_cnt == c_DB_LAST) begin
               w_state_nxt     = ST_HELD;
               w_press_nxt     = 1'b1;
               w_level_nxt     = 1'b1;
               w_hold_cnt_nxt  = '0;
               w_long_done_nxt = 1'b0;
            end else begin
               w_db_cnt_nxt = r_db_cnt + c_DB_ONE;
            end
         end

         ST_HELD: begin
            if (!w_key_act) begin
               // hold_cnt is left untouched so a rejected release glitch
               // resumes the long-press timer where it stopped
               w_state_nxt  = ST_RELEASE_DB;
               w_db_cnt_nxt = '0;
            end else if (!r_long_done && (r_hold_cnt == c_HOLD_LAST)) begin
               w_long_nxt      = 1'b1;
               w_long_done_nxt = 1'b1;
            end else if (!r_long_done) begin
               w_hold_cnt_nxt = r_hold_cnt + c_HOLD_ONE;
            end
         end

         ST_RELEASE_DB: begin
            if (w_key_act) begin
               w_state_nxt = ST_HELD;
            end else if (r_db_cnt == c_DB_LAST) begin
               w_state_nxt   = ST_IDLE;
               w_release_nxt = 1'b1;
               w_level_nxt   = 1'b0;
            end else begin
               w_db_cnt_nxt = r_db_cnt + c_DB_ONE;
            end
         end

         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   assign key_level   = r_level;
   assign key_press   = r_press;
   assign key_release = r_release;
   assign key_long    = r_long;

endmodule : key_debounce
`default_nettype wire

// File: tb/tb_key_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : tb_key_debounce
//  Description : Directed self-checking bench for key_debounce. Two instances
//                share clock and reset: an active-high key (A) and an
//                active-low key (B) whose pin idles high.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_key_debounce;

   localparam int DB = 4;
   localparam int LG = 16;
   // Edges from first active sample to the output pulse: 2 sync + DB
   localparam int LAT = DB + 2;

   logic clk   = 1'b0;
   logic rst   = 1'b1;
   logic key_a = 1'b0;
   logic key_b = 1'b1;

   logic lvl_a, prs_a, rel_a, lng_a;
   logic lvl_b, prs_b, rel_b, lng_b;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   key_debounce #(
      .DEBOUNCE_CYCLES (DB),
      .LONG_CYCLES     (LG),
      .ACTIVE_LEVEL    (1'b1)
   ) u_dut_hi (
      .sys_clk     (clk),
      .sys_rst     (rst),
      .key_in      (key_a),
      .key_level   (lvl_a),
      .key_press   (prs_a),
      .key_release (rel_a),
      .key_long    (lng_a)
   );

   key_debounce #(
      .DEBOUNCE_CYCLES (DB),
      .LONG_CYCLES     (LG),
      .ACTIVE_LEVEL    (1'b0)
   ) u_dut_lo (
      .sys_clk     (clk),
      .sys_rst     (rst),
      .key_in      (key_b),
      .key_level   (lvl_b),
      .key_press   (prs_b),
      .key_release (rel_b),
      .key_long    (lng_b)
   );

   // Advance past the next rising edge and sample 1 ns later
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_a(input logic v);
      @(negedge clk);
      key_a = v;
   endtask

   task automatic drive_b(input logic v);
      @(negedge clk);
      key_b = v;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) tick();
      checks++;
      if ({lvl_a, prs_a, rel_a, lng_a} !== 4'b0000) begin
         failures++;
         $display("FAIL reset_a got=%b exp=0000", {lvl_a, prs_a, rel_a, lng_a});
      end
      checks++;
      if ({lvl_b, prs_b, rel_b, lng_b} !== 4'b0000) begin
         failures++;
         $display("FAIL reset_b got=%b exp=0000", {lvl_b, prs_b, rel_b, lng_b});
      end
      @(negedge clk);
      rst = 1'b0;
      repeat (4) tick();
   endtask

   // Clean rise, then held: press at LAT edges, long press LG edges later
   task automatic test_press_and_long();
      int nlong;
      nlong = 0;
      drive_a(1'b1);
      tick();                              // first active sample, edge k
      for (int i = 1; i <= LAT + 2; i++) begin
         tick();                           // edge k+i
         checks++;
         if (prs_a !== (i == LAT)) begin
            failures++;
            $display("FAIL press_pulse edge=k+%0d got=%b exp=%b", i, prs_a, (i == LAT));
         end
         checks++;
         if (lvl_a !== (i >= LAT)) begin
            failures++;
            $display("FAIL press_level edge=k+%0d got=%b exp=%b", i, lvl_a, (i >= LAT));
         end
      end
      // Now at press edge P plus 2; hold for 30 more cycles
      for (int i = 3; i <= 32; i++) begin
         tick();                           // edge P+i
         if (lng_a === 1'b1) nlong++;
         checks++;
         if (lng_a !== (i == LG)) begin
            failures++;
            $display("FAIL long_pulse edge=P+%0d got=%b exp=%b", i, lng_a, (i == LG));
         end
         checks++;
         if ({prs_a, rel_a, lvl_a} !== 3'b001) begin
            failures++;
            $display("FAIL long_hold edge=P+%0d got=%b exp=001", i, {prs_a, rel_a, lvl_a});
         end
      end
      checks++;
      if (nlong != 1) begin
         failures++;
         $display("FAIL long_count got=%0d exp=1", nlong);
      end
   endtask

   // Sustained release from HELD: release pulse and level fall at LAT edges
   task automatic test_release();
      drive_a(1'b0);
      tick();                              // first inactive sample, edge r
      for (int i = 1; i <= LAT + 2; i++) begin
         tick();
         checks++;
         if (rel_a !== (i == LAT)) begin
            failures++;
            $display("FAIL release_pulse edge=r+%0d got=%b exp=%b", i, rel_a, (i == LAT));
         end
         checks++;
         if (lvl_a !== (i < LAT)) begin
            failures++;
            $display("FAIL release_level edge=r+%0d got=%b exp=%b", i, lvl_a, (i < LAT));
         end
         checks++;
         if ({prs_a, lng_a} !== 2'b00) begin
            failures++;
            $display("FAIL release_excl edge=r+%0d got=%b exp=00", i, {prs_a, lng_a});
         end
      end
      repeat (3) tick();
   endtask

   // High 3, low 2, then high and held: only the final rise is accepted
   task automatic test_bounce();
      logic [5:0] pat;
      pat = 6'b100111;                     // applied LSB first
      for (int i = 0; i < 6; i++) begin
         drive_a(pat[i]);
         tick();
         checks++;
         if ({prs_a, lvl_a} !== 2'b00) begin
            failures++;
            $display("FAIL bounce_quiet step=%0d got=%b exp=00", i, {prs_a, lvl_a});
         end
      end
      // Last tick above was edge f, the first sample of the final rise
      for (int i = 1; i <= LAT + 2; i++) begin
         tick();
         checks++;
         if (prs_a !== (i == LAT)) begin
            failures++;
            $display("FAIL bounce_press edge=f+%0d got=%b exp=%b", i, prs_a, (i == LAT));
         end
      end
      drive_a(1'b0);
      repeat (LAT + 4) tick();
      checks++;
      if (lvl_a !== 1'b0) begin
         failures++;
         $display("FAIL bounce_cleanup got=%b exp=0", lvl_a);
      end
   endtask

   // Pin low for samples P+3 and P+4 while HELD. FSM sees low at P+5
   // (HELD->RELEASE_DB) and P+6, and is back in HELD at P+7; those three
   // edges do not advance hold_cnt (4 after P+4), so hold_cnt reaches 15
   // after P+18 and key_long fires at P+19 instead of P+16.
   task automatic test_release_glitch();
      drive_a(1'b1);
      tick();
      repeat (LAT) tick();                 // press edge P
      checks++;
      if (prs_a !== 1'b1) begin
         failures++;
         $display("FAIL glitch_setup_press got=%b exp=1", prs_a);
      end
      for (int i = 1; i <= 25; i++) begin
         drive_a((i == 3 || i == 4) ? 1'b0 : 1'b1);
         tick();                           // edge P+i
         checks++;
         if (lng_a !== (i == 19)) begin
            failures++;
            $display("FAIL glitch_long edge=P+%0d got=%b exp=%b", i, lng_a, (i == 19));
         end
         checks++;
         if ({lvl_a, rel_a, prs_a} !== 3'b100) begin
            failures++;
            $display("FAIL glitch_level edge=P+%0d got=%b exp=100", i, {lvl_a, rel_a, prs_a});
         end
      end
      test_release();
   endtask

   // Reset asserted in HELD and in PRESS_DB with the key held throughout
   task automatic test_reset_mid();
      drive_a(1'b1);
      tick();
      repeat (LAT + 1) tick();             // one edge past press, HELD
      checks++;
      if (lvl_a !== 1'b1) begin
         failures++;
         $display("FAIL rstmid_setup_level got=%b exp=1", lvl_a);
      end
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if ({lvl_a, prs_a, rel_a, lng_a} !== 4'b0000) begin
         failures++;
         $display("FAIL rstmid_held_async got=%b exp=0000", {lvl_a, prs_a, rel_a, lng_a});
      end
      @(negedge clk);
      rst = 1'b0;
      tick();                              // first sample after reset, edge k
      for (int i = 1; i <= LAT + 1; i++) begin
         tick();
         checks++;
         if ({prs_a, lvl_a} !== {(i == LAT), (i >= LAT)}) begin
            failures++;
            $display("FAIL rstmid_held_repress edge=k+%0d got=%b exp=%b", i,
                     {prs_a, lvl_a}, {(i == LAT), (i >= LAT)});
         end
      end
      drive_a(1'b0);
      repeat (LAT + 4) tick();

      // Second pass: reset while still debouncing the press
      drive_a(1'b1);
      tick();                              // edge k
      repeat (3) tick();                   // k+3, inside PRESS_DB
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if ({lvl_a, prs_a, rel_a, lng_a} !== 4'b0000) begin
         failures++;
         $display("FAIL rstmid_db_async got=%b exp=0000", {lvl_a, prs_a, rel_a, lng_a});
      end
      @(negedge clk);
      rst = 1'b0;
      tick();
      for (int i = 1; i <= LAT + 1; i++) begin
         tick();
         checks++;
         if ({prs_a, lvl_a} !== {(i == LAT), (i >= LAT)}) begin
            failures++;
            $display("FAIL rstmid_db_repress edge=k+%0d got=%b exp=%b", i,
                     {prs_a, lvl_a}, {(i == LAT), (i >= LAT)});
         end
      end
      drive_a(1'b0);
      repeat (LAT + 4) tick();
   endtask

   // Active-low key idling high: silent until pulled low
   task automatic test_polarity();
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++;
         if ({lvl_b, prs_b, rel_b, lng_b} !== 4'b0000) begin
            failures++;
            $display("FAIL pol_idle step=%0d got=%b exp=0000", i, {lvl_b, prs_b, rel_b, lng_b});
         end
      end
      drive_b(1'b0);
      tick();
      for (int i = 1; i <= LAT + 1; i++) begin
         tick();
         checks++;
         if ({prs_b, lvl_b} !== {(i == LAT), (i >= LAT)}) begin
            failures++;
            $display("FAIL pol_press edge=k+%0d got=%b exp=%b", i,
                     {prs_b, lvl_b}, {(i == LAT), (i >= LAT)});
         end
      end
      drive_b(1'b1);
      tick();
      for (int i = 1; i <= LAT + 1; i++) begin
         tick();
         checks++;
         if ({rel_b, lvl_b} !== {(i == LAT), (i < LAT)}) begin
            failures++;
            $display("FAIL pol_release edge=r+%0d got=%b exp=%b", i,
                     {rel_b, lvl_b}, {(i == LAT), (i < LAT)});
         end
      end
   endtask

   initial begin
      test_reset();
      test_press_and_long();
      test_release();
      test_bounce();
      test_release_glitch();
      test_reset_mid();
      test_polarity();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_key_debounce
`default_nettype wire
